// File: rtl/intc_pkg.sv
// rtl/intc_pkg.sv - shared types and constants for the round-robin interrupt controller
package intc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        SERVICE = 2'd2
    } state_t;

    localparam int ID_W = 4;

    localparam int PENDING_OFF = 0;
    localparam int MASK_OFF    = 4;
    localparam int CLAIM_OFF   = 8;
    localparam int CTRL_OFF    = 12;
    localparam int EOI_OFF     = 16;
    localparam int OVERRUN_OFF = 20;

    localparam int CTRL_GEN      = 0;
    localparam int CTRL_INSVC_LO = 4;
    localparam int CTRL_INSVC_HI = 7;
    localparam int CTRL_INTR     = 8;
    localparam int CTRL_OVR      = 9;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin winner search starting at a pointer
module rr_picker #(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = 4
) (
    input  logic [NUM_SRC-1:0] eligible,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    winner,
    output logic               valid
);

    int idx;

    // Scan from the farthest offset down so the closest eligible index at or after ptr wins
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_SRC) begin
                idx = idx - NUM_SRC;
            end
            if (|(eligible & (NUM_SRC'(1) << idx))) begin
                winner = ID_W'(idx);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/intc_rr_controller.sv
// rtl/intc_rr_controller.sv - memory-mapped round-robin interrupt controller (optional INTC_OVERRUN_EN)
module intc_rr_controller
    import intc_pkg::*;
#(
    parameter int              BITS    = 32,
    parameter int              NUM_SRC = 4,
    parameter logic [BITS-1:0] BASE    = 32'hF0000100
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               we,
    input  logic               re,
    input  logic [BITS-1:0]    memAddr,
    input  logic [BITS-1:0]    dataBusIn,
    input  logic [NUM_SRC-1:0] irqReq,
    output logic               intr,
    output logic [BITS-1:0]    dataBusOut
);

    state_t             state;
    logic [ID_W-1:0]    sel_id;
    logic [ID_W-1:0]    in_service;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    next_ptr;
    logic [NUM_SRC-1:0] irq_prev;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] mask;
    logic               gen;
    logic [NUM_SRC-1:0] pend_n;
    logic [NUM_SRC-1:0] mask_n;
    logic               gen_n;
    logic [NUM_SRC-1:0] edges;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] sel_oh;
    logic [ID_W-1:0]    winner;
    logic               win_valid;
    logic [BITS-1:0]    off;
    logic               rd_en;
    logic               wr_pend, wr_mask, wr_ctrl, wr_eoi;
    logic               rd_claim, claim;
    logic               ovr_any;
    logic               unused_bits;

    assign off      = memAddr - BASE;
    assign rd_en    = re & ~we;
    assign wr_pend  = we & (off == BITS'(PENDING_OFF));
    assign wr_mask  = we & (off == BITS'(MASK_OFF));
    assign wr_ctrl  = we & (off == BITS'(CTRL_OFF));
    assign wr_eoi   = we & (off == BITS'(EOI_OFF));
    assign rd_claim = rd_en & (off == BITS'(CLAIM_OFF));
    assign claim    = rd_claim & (state == ASSERT);

    assign edges    = irqReq & ~irq_prev;
    assign eligible = pending & mask;
    assign sel_oh   = NUM_SRC'(1) << sel_id;
    assign mask_n   = wr_mask ? dataBusIn[NUM_SRC-1:0] : mask;
    assign gen_n    = wr_ctrl ? dataBusIn[CTRL_GEN] : gen;
    assign next_ptr = ({1'b0, in_service} >= (ID_W + 1)'(NUM_SRC)) ? '0 : in_service;

    assign unused_bits = ^dataBusIn;

    // Next pending: clears first, new edges last so a set beats a same-cycle clear
    always_comb begin
        pend_n = pending;
        if (wr_pend) begin
            pend_n = pend_n & ~dataBusIn[NUM_SRC-1:0];
        end
        if (claim) begin
            pend_n = pend_n & ~sel_oh;
        end
        pend_n = pend_n | edges;
    end

    rr_picker #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_picker (
        .eligible (eligible),
        .ptr      (rr_ptr),
        .winner   (winner),
        .valid    (win_valid)
    );

    // Edge history, pending, mask and global enable
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_prev <= '0;
            pending  <= '0;
            mask     <= '0;
            gen      <= 1'b0;
        end else begin
            irq_prev <= irqReq;
            pending  <= pend_n;
            mask     <= mask_n;
            gen      <= gen_n;
        end
    end

    // Arbitration / claim / EOI sequencing; intr rises on the second ASSERT cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            sel_id     <= '0;
            intr       <= 1'b0;
            in_service <= '0;
            rr_ptr     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    intr <= 1'b0;
                    if (gen && win_valid) begin
                        sel_id <= winner;
                        state  <= ASSERT;
                    end
                end
                ASSERT: begin
                    if (claim) begin
                        in_service <= sel_id + 1'b1;
                        state      <= SERVICE;
                        intr       <= 1'b0;
                    end else if (!(|(pend_n & mask_n & sel_oh)) || !gen_n) begin
                        state <= IDLE;
                        intr  <= 1'b0;
                    end else begin
                        intr <= 1'b1;
                    end
                end
                SERVICE: begin
                    intr <= 1'b0;
                    if (wr_eoi && (dataBusIn[ID_W-1:0] == in_service)) begin
                        in_service <= '0;
                        rr_ptr     <= next_ptr;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    intr  <= 1'b0;
                end
            endcase
        end
    end

`ifdef INTC_OVERRUN_EN
    logic [NUM_SRC-1:0] ovr;
    logic               wr_ovr;

    assign wr_ovr  = we & (off == BITS'(OVERRUN_OFF));
    assign ovr_any = |ovr;

    // Sticky overrun: an edge on an already-pending source, set beats W1C
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovr <= '0;
        end else begin
            ovr <= (wr_ovr ? (ovr & ~dataBusIn[NUM_SRC-1:0]) : ovr) | (edges & pending);
        end
    end
`else
    assign ovr_any = 1'b0;
`endif

    // Combinational read mux; zero unless a register of this block is read
    always_comb begin
        dataBusOut = '0;
        if (rd_en) begin
            if (off == BITS'(PENDING_OFF)) begin
                dataBusOut = BITS'(pending);
            end else if (off == BITS'(MASK_OFF)) begin
                dataBusOut = BITS'(mask);
            end else if (off == BITS'(CLAIM_OFF)) begin
                dataBusOut = (state == ASSERT) ? BITS'(sel_id + 1'b1) : '0;
            end else if (off == BITS'(CTRL_OFF)) begin
                dataBusOut[CTRL_GEN]                     = gen;
                dataBusOut[CTRL_INSVC_HI:CTRL_INSVC_LO]  = in_service;
                dataBusOut[CTRL_INTR]                    = intr;
                dataBusOut[CTRL_OVR]                     = ovr_any;
`ifdef INTC_OVERRUN_EN
            end else if (off == BITS'(OVERRUN_OFF)) begin
                dataBusOut = BITS'(ovr);
`endif
            end
        end
    end

endmodule

// File: tb/tb_intc_rr_controller.sv
// tb/tb_intc_rr_controller.sv - self-checking bench for intc_rr_controller with a cycle reference model
module tb_intc_rr_controller;

    localparam int          N    = 4;
    localparam logic [31:0] BASE = 32'hF0000100;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         we = 1'b0;
    logic         re = 1'b0;
    logic [31:0]  memAddr = '0;
    logic [31:0]  dataBusIn = '0;
    logic [N-1:0] irqReq = '0;
    logic         intr;
    logic [31:0]  dataBusOut;

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 1'b0;

    intc_rr_controller #(.BITS(32), .NUM_SRC(N), .BASE(BASE)) dut (
        .clk        (clk),
        .reset      (reset),
        .we         (we),
        .re         (re),
        .memAddr    (memAddr),
        .dataBusIn  (dataBusIn),
        .irqReq     (irqReq),
        .intr       (intr),
        .dataBusOut (dataBusOut)
    );

    always #5 clk = ~clk;

    // Reference model: armed source (-1 none), cycles spent armed, ID in service (0 none)
    logic [N-1:0] m_pend = '0, m_mask = '0, m_prev = '0, m_ovr = '0;
    logic         m_gen = 1'b0;
    int           m_arm = -1, m_cyc = 0, m_insvc = 0, m_ptr = 0;
    logic [31:0]  ma;
    logic         m_claim, gn;
    logic [N-1:0] ed, pn, mn;

    function automatic logic m_intr();
        return (m_arm >= 0) && (m_cyc >= 1);
    endfunction

    function automatic logic [31:0] exp_read();
        logic [31:0] a;
        a = memAddr - BASE;
        if (!(re && !we)) return 32'h0;
        case (a)
            32'd0:  return {28'h0, m_pend};
            32'd4:  return {28'h0, m_mask};
            32'd8:  return (m_arm >= 0) ? 32'(m_arm + 1) : 32'h0;
            32'd12: return {22'h0, |m_ovr, m_intr(), 4'(m_insvc), 3'h0, m_gen};
`ifdef INTC_OVERRUN_EN
            32'd20: return {28'h0, m_ovr};
`endif
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_pend = '0; m_mask = '0; m_prev = '0; m_ovr = '0; m_gen = 1'b0;
            m_arm = -1; m_cyc = 0; m_insvc = 0; m_ptr = 0;
        end else begin
            ma      = memAddr - BASE;
            m_claim = re && !we && (ma == 32'd8) && (m_arm >= 0);
            ed      = irqReq & ~m_prev;
`ifdef INTC_OVERRUN_EN
            if (we && ma == 32'd20) m_ovr = m_ovr & ~dataBusIn[N-1:0];
            m_ovr = m_ovr | (ed & m_pend);
`endif
            pn = m_pend;
            if (we && ma == 32'd0) pn = pn & ~dataBusIn[N-1:0];
            if (m_claim) pn[m_arm] = 1'b0;
            pn = pn | ed;
            mn = (we && ma == 32'd4) ? dataBusIn[N-1:0] : m_mask;
            gn = (we && ma == 32'd12) ? dataBusIn[0] : m_gen;
            if (m_arm >= 0) begin
                if (m_claim) begin
                    m_insvc = m_arm + 1;
                    m_arm = -1;
                end else if (!(pn[m_arm] && mn[m_arm]) || !gn) begin
                    m_arm = -1;
                end else begin
                    m_cyc++;
                end
            end else if (m_insvc != 0) begin
                if (we && ma == 32'd16 && int'(dataBusIn[3:0]) == m_insvc) begin
                    m_ptr = m_insvc % N;
                    m_insvc = 0;
                end
            end else if (m_gen) begin
                for (int k = N - 1; k >= 0; k--) begin
                    if (m_pend[(m_ptr + k) % N] && m_mask[(m_ptr + k) % N]) begin
                        m_arm = (m_ptr + k) % N;
                    end
                end
                m_cyc = 0;
            end
            m_pend = pn; m_mask = mn; m_gen = gn; m_prev = irqReq;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (started) begin
            chk("model_intr", {31'h0, intr}, {31'h0, m_intr()});
            chk("model_rdata", dataBusOut, exp_read());
        end
    end

    // All tasks start and end 1 time unit after a rising edge
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input int o, input logic [31:0] d);
        we = 1'b1; memAddr = BASE + 32'(o); dataBusIn = d;
        idle(1);
        we = 1'b0; memAddr = '0; dataBusIn = '0;
    endtask

    task automatic rd(input string name, input int o, input logic [31:0] exp);
        re = 1'b1; memAddr = BASE + 32'(o);
        @(negedge clk);
        chk(name, dataBusOut, exp);
        idle(1);
        re = 1'b0; memAddr = '0;
    endtask

    task automatic pulse(input logic [N-1:0] m);
        irqReq = m;
        idle(1);
        irqReq = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_intr", {31'h0, intr}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        started = 1'b1;
        rd("rst_pending", 0, 32'h0);
        rd("rst_mask", 4, 32'h0);
        rd("rst_claim", 8, 32'h0);
        rd("rst_ctrl", 12, 32'h0);

        // Single source 2: three-edge latency, claim, EOI
        wr(4, 32'hF);
        wr(12, 32'h1);
        pulse(4'b0100);
        chk("lat_edge1", {31'h0, intr}, 32'h0);
        idle(1);
        chk("lat_edge2", {31'h0, intr}, 32'h0);
        idle(1);
        chk("lat_edge3", {31'h0, intr}, 32'h1);
        rd("claim_src2", 8, 32'd3);
        chk("intr_after_claim", {31'h0, intr}, 32'h0);
        rd("ctrl_insvc3", 12, 32'h31);
        wr(16, 32'd3);
        rd("ctrl_after_eoi3", 12, 32'h01);

        // Source 0 serviced to move the pointer to 1
        pulse(4'b0001);
        idle(2);
        rd("claim_src0", 8, 32'd1);
        wr(16, 32'd1);

        // Sources 0 and 2 with pointer 1: 2 first, then wrap to 0
        pulse(4'b0101);
        idle(2);
        rd("pend_0_2", 0, 32'h5);
        rd("rr_first", 8, 32'd3);
        wr(16, 32'd3);
        idle(2);
        rd("rr_wrap", 8, 32'd1);
        wr(16, 32'd1);

        // Mask drop while asserting source 1
        pulse(4'b0010);
        idle(2);
        chk("assert_src1", {31'h0, intr}, 32'h1);
        rd("ctrl_intr_mirror", 12, 32'h101);
        wr(4, 32'hD);
        chk("intr_after_mask", {31'h0, intr}, 32'h0);
        rd("claim_after_drop", 8, 32'h0);
        rd("pend_kept", 0, 32'h2);
        wr(4, 32'hF);
        idle(2);
        rd("claim_src1", 8, 32'd2);

        // Mismatched EOI ignored, matching accepted
        wr(16, 32'd1);
        rd("eoi_mismatch", 12, 32'h21);
        wr(16, 32'd2);
        rd("eoi_match", 12, 32'h01);

        // Reset mid-ASSERT
        pulse(4'b1000);
        idle(2);
        chk("assert_src3", {31'h0, intr}, 32'h1);
        reset = 1'b0;
        #1;
        chk("reset_drop_intr", {31'h0, intr}, 32'h0);
        idle(1);
        reset = 1'b1;
        rd("post_rst_pend", 0, 32'h0);
        rd("post_rst_ctrl", 12, 32'h0);

        // Double edge on source 0 with GEN off, then W1C
        pulse(4'b0001);
        idle(1);
        pulse(4'b0001);
        idle(1);
`ifdef INTC_OVERRUN_EN
        rd("ovr_set", 20, 32'h1);
        rd("ctrl_ovr", 12, 32'h200);
        wr(20, 32'h1);
        rd("ovr_clear", 20, 32'h0);
`else
        rd("ovr_absent", 20, 32'h0);
        rd("ctrl_no_ovr", 12, 32'h0);
`endif
        rd("pend_before_w1c", 0, 32'h1);
        wr(0, 32'h1);
        rd("pend_after_w1c", 0, 32'h0);

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
